system_ram_arbiter: RTL and testbench
=====================================

SYSTEM_RAM_ARBITER -- requirements
Module: system_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word address width of the shared RAM.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive accepted transfers per master while the other master waits.
REQ-004 clk  in  1  single clock for all logic; reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 mN_address  in  ADDR_W  master N word address (N = 0, 1).
REQ-007 mN_byteenable  in  DATA_W/8  master N byte lanes.
REQ-008 mN_read / mN_write  in  1 each  master N read or write request.
REQ-009 mN_writedata  in  DATA_W  master N write data.
REQ-010 mN_waitrequest  out  1  high = master N request not accepted this cycle.
REQ-011 mN_readdata  out  DATA_W  master N read data.
REQ-012 mN_readdatavalid  out  1  master N read data valid.
REQ-013 ram_address / ram_byteenable / ram_writedata  out  ADDR_W / DATA_W/8 / DATA_W  RAM port drive.
REQ-014 ram_chipselect / ram_write / ram_clken  out  1 each  RAM control.
REQ-015 ram_readdata  in  DATA_W  RAM output, valid one cycle after address is registered.

Function
REQ-016 A master is requesting when mN_read or mN_write is high; at most one master is granted per cycle, combinationally, in the same cycle.
REQ-017 Granted master sees mN_waitrequest=0; the transfer is accepted at the next rising clk edge; the non-granted requester sees mN_waitrequest=1 and holds its request.
REQ-018 A non-requesting master sees mN_waitrequest=1.
REQ-019 Grant FSM states: IDLE, OWN0, OWN1; IDLE->OWNn on accepted transfer by n; OWNn stays while n requests and burst count < MAX_BURST; otherwise moves to OWNm if m requests, else IDLE.
REQ-020 In IDLE with both requesting, grant goes to the master not granted last (round-robin pointer); after reset the pointer favours m0.
REQ-021 In OWNn with only n requesting, n keeps the grant indefinitely; the burst counter saturates and does not force a yield.
REQ-022 Burst counter is 0 in IDLE, increments per accepted transfer of the owner, and resets to 1 on ownership change.
REQ-023 When the count reaches MAX_BURST and the other master requests, the owner is refused for the next cycle and the other master is granted.
REQ-024 Granted transfer drives ram_address, ram_byteenable, ram_writedata from the winner; ram_chipselect=1; ram_write=mN_write.
REQ-025 With no grant, ram_chipselect=0, ram_write=0, and the address/data outputs hold their last values.
REQ-026 ram_clken is 1 except during reset.
REQ-027 Read latency is fixed at 1 cycle: a read accepted at edge k asserts mN_readdatavalid for exactly the cycle after edge k, with mN_readdata = ram_readdata.
REQ-028 mN_readdata reflects ram_readdata for both masters at all times; only readdatavalid is steered.
REQ-029 Back-to-back reads are accepted every cycle, giving one valid per cycle.
REQ-030 If read and write are both high on a granted master, the write is performed and no readdatavalid is produced.
REQ-031 A write followed by a read of the same address in the next cycle returns the new data.

Reset
REQ-032 While reset is high: FSM=IDLE, burst count=0, RR pointer favours m0, both waitrequest=1, both readdatavalid=0, ram_chipselect=0, ram_write=0, ram_clken=0.
REQ-033 A reset asserted with a read in flight cancels its readdatavalid; no transfer is accepted during a reset cycle.

Structure
REQ-034 Package system_ram_arbiter_pkg holds the FSM state enum, default widths, and the MAX_BURST default.
REQ-035 Sub-module system_ram_rr_grant holds the 2-way round-robin/burst grant logic; the top level handles muxing and the readdatavalid pipeline.

Verification
REQ-036 m0 reads addr 0x010 (preloaded 0xDEADBEEF), m1 idle -> m0_waitrequest=0 in cycle 0; m0_readdatavalid=1 with 0xDEADBEEF in cycle 1 only.
REQ-037 Both masters read continuously from reset -> grants m0 x4, m1 x4, m0 x4; each valid lands on the correct master 1 cycle after its acceptance.
REQ-038 m1 writes 0x12345678 to 0x3FF with byteenable 0x3, then reads 0x3FF -> old upper bytes, lower bytes 0x5678.
REQ-039 m0 streams 10 writes alone -> no stall, m1_waitrequest=1 throughout, ram_write=1 for 10 cycles.
REQ-040 Reset pulsed the cycle after m0 read acceptance -> m0_readdatavalid stays 0; first post-reset tie is granted to m0.

Source files
------------

// File: rtl/system_ram_arbiter_pkg.sv
// Shared types and default widths for the two-master system RAM arbiter.
package system_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } grant_state_t;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 4;

  // Counter must be able to hold MAX_BURST itself so it can saturate there.
  function automatic int burst_cnt_w(input int max_burst);
    return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/system_ram_rr_grant.sv
// Two-way round-robin grant with burst limit; grant is combinational in the request cycle.
// Owner keeps the grant up to MAX_BURST transfers while the other master waits, indefinitely when alone.
module system_ram_rr_grant
  import system_ram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam int CNT_W = burst_cnt_w(MAX_BURST);

  grant_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last1, last1_nxt;
  logic             at_max;

  assign at_max = (cnt >= CNT_W'(MAX_BURST));

  // last1 = 1 means m1 was granted most recently, so an IDLE tie goes to m0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last1 <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last1 <= last1_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt   = '0;
    last1_nxt = last1;
    if (gnt0) begin
      state_nxt = ST_OWN0;
      last1_nxt = 1'b0;
      if (state == ST_OWN0) cnt_nxt = at_max ? cnt : cnt + CNT_W'(1);
      else                  cnt_nxt = CNT_W'(1);
    end else if (gnt1) begin
      state_nxt = ST_OWN1;
      last1_nxt = 1'b1;
      if (state == ST_OWN1) cnt_nxt = at_max ? cnt : cnt + CNT_W'(1);
      else                  cnt_nxt = CNT_W'(1);
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          if (req0 && req1) begin
            gnt0 = last1;
            gnt1 = !last1;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        ST_OWN0: begin
          if (req0 && !(at_max && req1)) gnt0 = 1'b1;
          else                           gnt1 = req1;
        end
        ST_OWN1: begin
          if (req1 && !(at_max && req0)) gnt1 = 1'b1;
          else                           gnt0 = req0;
        end
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/system_ram_arbiter.sv
// Arbitrates two masters onto one synchronous RAM port; reads return data one cycle after acceptance.
// A master is stalled with waitrequest until granted and must hold its request meanwhile.
module system_ram_arbiter
  import system_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int BE_W = DATA_W / 8;

  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        rdv_q;

  system_ram_rr_grant #(.MAX_BURST(MAX_BURST)) u_grant (
    .clk   (clk),
    .reset (reset),
    .req0  (m0_read | m0_write),
    .req1  (m1_read | m1_write),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign m0_waitrequest = !gnt0;
  assign m1_waitrequest = !gnt1;
  assign ram_clken      = !reset;

  // Idle cycles replay the last granted address/data so the RAM inputs stay quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (gnt0) begin
      addr_q  <= m0_address;
      be_q    <= m0_byteenable;
      wdata_q <= m0_writedata;
    end else if (gnt1) begin
      addr_q  <= m1_address;
      be_q    <= m1_byteenable;
      wdata_q <= m1_writedata;
    end
  end

  always_comb begin
    ram_address    = addr_q;
    ram_byteenable = be_q;
    ram_writedata  = wdata_q;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    if (gnt0) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
      ram_chipselect = 1'b1;
      ram_write      = m0_write;
    end else if (gnt1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
      ram_chipselect = 1'b1;
      ram_write      = m1_write;
    end
  end

  // A read+write request is a write, so it never produces a read response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdv_q <= 2'b00;
    end else begin
      rdv_q[0] <= gnt0 && m0_read && !m0_write;
      rdv_q[1] <= gnt1 && m1_read && !m1_write;
    end
  end

  assign m0_readdatavalid = rdv_q[0] && !reset;
  assign m1_readdatavalid = rdv_q[1] && !reset;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_system_ram_arbiter.sv
// Self-checking bench: directed scenarios, a cycle table, and a randomized run against a reference model.
module tb_system_ram_arbiter;
  import system_ram_arbiter_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd [2];
  logic          wr [2];
  logic [AW-1:0] ad [2];
  logic [BW-1:0] be [2];
  logic [DW-1:0] wd [2];
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic [DW-1:0] ram_writedata;
  logic          ram_chipselect, ram_write, ram_clken;
  logic [DW-1:0] ram_readdata = '0;
  logic          do_preload;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  system_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .m0_address(ad[0]), .m0_byteenable(be[0]), .m0_read(rd[0]), .m0_write(wr[0]),
    .m0_writedata(wd[0]), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(ad[1]), .m1_byteenable(be[1]), .m1_read(rd[1]), .m1_write(wr[1]),
    .m1_writedata(wd[1]), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 'h010) return 32'hDEADBEEF;
    if (i == 'h3FF) return 32'hAABBCCDD;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] lanes);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (lanes[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Synchronous RAM with one-cycle read latency, driven by the DUT's RAM port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (do_preload) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
    end else if (ram_clken && ram_chipselect) begin
      if (ram_write) mem[ram_address] <= merge(mem[ram_address], ram_writedata, ram_byteenable);
      else           ram_readdata     <= mem[ram_address];
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [BW-1:0] e, input logic [DW-1:0] d);
    rd[m] = r; wr[m] = w; ad[m] = a; be[m] = e; wd[m] = d;
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic settle();
    #5;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic rst, r0, w0, r1, w1;
    logic wr0, wr1, cs, wrt, rdv0, rdv1;
  } vec_t;
  vec_t tbl [16];

  // Reference model state: who was granted last, and the current run of grants.
  int            m_last, m_owner, m_streak;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic int model_winner(input logic q0, input logic q1);
    if (!q0 && !q1) return -1;
    if (q0 && !q1)  return 0;
    if (q1 && !q0)  return 1;
    if (m_owner < 0) return 1 - m_last;
    if (m_streak >= MB) return 1 - m_owner;
    return m_owner;
  endfunction

  initial begin
    int w, k, stalls, wcycles;
    logic pend [2];
    logic e_rdv [2];
    logic [DW-1:0] e_dat;

    reset = 1'b1;
    do_preload = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    do_preload = 1'b0;
    settle();
    chk("rst_wait0", m0_waitrequest, 1);
    chk("rst_wait1", m1_waitrequest, 1);
    chk("rst_cs", ram_chipselect, 0);
    chk("rst_clken", ram_clken, 0);
    chk("rst_rdv0", m0_readdatavalid, 0);

    // Single read of preloaded word.
    next_cycle();
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 10'h010, 4'hF, '0);
    settle();
    chk("rd1_wait0", m0_waitrequest, 0);
    chk("rd1_wait1", m1_waitrequest, 1);
    chk("rd1_addr", 32'(ram_address), 32'h010);
    chk("rd1_clken", ram_clken, 1);
    next_cycle();
    idle_all();
    settle();
    chk("rd1_rdv0", m0_readdatavalid, 1);
    chk("rd1_data", m0_readdata, 32'hDEADBEEF);
    chk("rd1_rdv1", m1_readdatavalid, 0);
    chk("rd1_idle_cs", ram_chipselect, 0);
    chk("rd1_hold_addr", 32'(ram_address), 32'h010);
    next_cycle();
    settle();
    chk("rd1_rdv0_once", m0_readdatavalid, 0);

    // Partial-lane write, then read back in the very next cycle.
    next_cycle();
    drive(1, 1'b0, 1'b1, 10'h3FF, 4'h3, 32'h12345678);
    settle();
    chk("be_wait1", m1_waitrequest, 0);
    chk("be_write", ram_write, 1);
    chk("be_lanes", 32'(ram_byteenable), 32'h3);
    next_cycle();
    drive(1, 1'b1, 1'b0, 10'h3FF, 4'hF, '0);
    settle();
    chk("be_rd_wait1", m1_waitrequest, 0);
    chk("be_rd_write", ram_write, 0);
    next_cycle();
    idle_all();
    settle();
    chk("be_rdv1", m1_readdatavalid, 1);
    chk("be_rdv0", m0_readdatavalid, 0);
    chk("be_data", m1_readdata, 32'hAABB5678);

    // Ten writes from m0 alone: never stalled despite burst limit.
    stalls = 0;
    wcycles = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      drive(0, 1'b0, 1'b1, AW'(10'h100 + i), 4'hF, 32'(i));
      settle();
      if (m0_waitrequest) stalls++;
      if (ram_write) wcycles++;
      chk("wstream_wait1", m1_waitrequest, 1);
    end
    chk("wstream_stalls", 32'(stalls), 0);
    chk("wstream_wcycles", 32'(wcycles), 10);
    next_cycle();
    idle_all();
    settle();
    chk("wstream_end_write", ram_write, 0);

    // Reset right after a read is accepted cancels its response; tie then goes to m0.
    next_cycle();
    drive(0, 1'b1, 1'b0, 10'h010, 4'hF, '0);
    settle();
    chk("rstc_acc", m0_waitrequest, 0);
    next_cycle();
    reset = 1'b1;
    idle_all();
    settle();
    chk("rstc_rdv0", m0_readdatavalid, 0);
    chk("rstc_clken", ram_clken, 0);
    next_cycle();
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 10'h010, 4'hF, '0);
    drive(1, 1'b1, 1'b0, 10'h020, 4'hF, '0);
    settle();
    chk("rstc_tie_wait0", m0_waitrequest, 0);
    chk("rstc_tie_wait1", m1_waitrequest, 1);
    next_cycle();
    idle_all();
    settle();
    chk("rstc_post_rdv0", m0_readdatavalid, 1);
    chk("rstc_post_data", m0_readdata, 32'hDEADBEEF);

    // Cycle table: rst r0 w0 r1 w1 | wait0 wait1 cs write rdv0 rdv1
    tbl[0]  = '{1,1,0,1,0, 1,1,0,0,0,0};
    tbl[1]  = '{0,1,0,1,0, 0,1,1,0,0,0};
    tbl[2]  = '{0,1,0,1,0, 0,1,1,0,1,0};
    tbl[3]  = '{0,1,0,1,0, 0,1,1,0,1,0};
    tbl[4]  = '{0,1,0,1,0, 0,1,1,0,1,0};
    tbl[5]  = '{0,1,0,1,0, 1,0,1,0,1,0};
    tbl[6]  = '{0,1,0,1,0, 1,0,1,0,0,1};
    tbl[7]  = '{0,1,0,1,0, 1,0,1,0,0,1};
    tbl[8]  = '{0,1,0,1,0, 1,0,1,0,0,1};
    tbl[9]  = '{0,1,0,1,0, 0,1,1,0,0,1};
    tbl[10] = '{0,0,0,0,0, 1,1,0,0,1,0};
    tbl[11] = '{0,1,0,1,0, 1,0,1,0,0,0};
    tbl[12] = '{0,0,1,0,0, 0,1,1,1,0,1};
    tbl[13] = '{0,1,1,0,0, 0,1,1,1,0,0};
    tbl[14] = '{0,0,0,0,0, 1,1,0,0,0,0};
    tbl[15] = '{1,1,0,0,0, 1,1,0,0,0,0};
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      reset = tbl[i].rst;
      drive(0, tbl[i].r0, tbl[i].w0, 10'h020, 4'hF, 32'hC0DE0000 + 32'(i));
      drive(1, tbl[i].r1, tbl[i].w1, 10'h030, 4'hF, 32'hBEEF0000 + 32'(i));
      settle();
      chk($sformatf("tbl%0d_wait0", i), m0_waitrequest, tbl[i].wr0);
      chk($sformatf("tbl%0d_wait1", i), m1_waitrequest, tbl[i].wr1);
      chk($sformatf("tbl%0d_cs", i), ram_chipselect, tbl[i].cs);
      chk($sformatf("tbl%0d_write", i), ram_write, tbl[i].wrt);
      chk($sformatf("tbl%0d_rdv0", i), m0_readdatavalid, tbl[i].rdv0);
      chk($sformatf("tbl%0d_rdv1", i), m1_readdatavalid, tbl[i].rdv1);
      chk($sformatf("tbl%0d_clken", i), ram_clken, !tbl[i].rst);
    end

    // Randomized traffic against the reference model, starting from a fresh preload.
    next_cycle();
    reset = 1'b1;
    do_preload = 1'b1;
    idle_all();
    next_cycle();
    do_preload = 1'b0;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    m_last = 1; m_owner = -1; m_streak = 0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    e_rdv[0] = 1'b0; e_rdv[1] = 1'b0;
    e_dat = '0;
    for (int c = 0; c < 800; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m]) begin
          if ($urandom_range(0, 9) < 7) begin
            k = $urandom_range(0, 3);
            drive(m, k != 2, k >= 2, AW'($urandom_range(0, 15)), BW'($urandom_range(1, 15)), $urandom);
            pend[m] = 1'b1;
          end else begin
            drive(m, 1'b0, 1'b0, AW'($urandom_range(0, 15)), '0, $urandom);
          end
        end
      end
      w = model_winner(rd[0] | wr[0], rd[1] | wr[1]);
      settle();
      chk("rnd_wait0", m0_waitrequest, w != 0);
      chk("rnd_wait1", m1_waitrequest, w != 1);
      chk("rnd_cs", ram_chipselect, w >= 0);
      chk("rnd_rdv0", m0_readdatavalid, e_rdv[0]);
      chk("rnd_rdv1", m1_readdatavalid, e_rdv[1]);
      if (e_rdv[0]) chk("rnd_data0", m0_readdata, e_dat);
      if (e_rdv[1]) chk("rnd_data1", m1_readdata, e_dat);
      e_rdv[0] = 1'b0;
      e_rdv[1] = 1'b0;
      if (w >= 0) begin
        chk("rnd_write", ram_write, wr[w]);
        chk("rnd_addr", 32'(ram_address), 32'(ad[w]));
        if (wr[w]) begin
          chk("rnd_wdata", ram_writedata, wd[w]);
          chk("rnd_lanes", 32'(ram_byteenable), 32'(be[w]));
          ref_mem[ad[w]] = merge(ref_mem[ad[w]], wd[w], be[w]);
        end else begin
          e_rdv[w] = 1'b1;
          e_dat = ref_mem[ad[w]];
        end
        pend[w] = 1'b0;
        if (w == m_owner) m_streak++;
        else begin
          m_owner = w;
          m_streak = 1;
        end
        m_last = w;
      end else begin
        chk("rnd_write_idle", ram_write, 0);
        m_owner = -1;
        m_streak = 0;
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
